// File: rtl/btn_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_pkg
//  Description : Shared types and default constants for the button debounce
//                bank: per-channel FSM state encoding, parameter defaults and
//                a small sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_debounce_pkg;

    // Default configuration of the bank
    localparam int c_N_CH_DEFAULT         = 4;
    localparam int c_TICK_DIV_DEFAULT     = 250000;
    localparam int c_STABLE_CNT_DEFAULT   = 4;
    localparam int c_REPEAT_EN_DEFAULT    = 1;
    localparam int c_HOLD_TICKS_DEFAULT   = 100;
    localparam int c_REPEAT_TICKS_DEFAULT = 25;

    // Per-channel auto-repeat state
    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEATING = 2'd2
    } btn_state_e;

    // Larger of two integers, used to size the shared repeat counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : btn_debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One button channel: two-flop synchronizer, tick-sampled
//                stability counter producing a debounced level with
//                press/release pulses, and a hold/auto-repeat FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_CNT   = c_STABLE_CNT_DEFAULT,
    parameter int REPEAT_EN    = c_REPEAT_EN_DEFAULT,
    parameter int HOLD_TICKS   = c_HOLD_TICKS_DEFAULT,
    parameter int REPEAT_TICKS = c_REPEAT_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pb_in,
    output logic pb_level,
    output logic pb_press,
    output logic pb_release,
    output logic pb_repeat,
    output logic press_set
);

    localparam int STB_W = $clog2(STABLE_CNT + 1);
    localparam int RPT_W = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);

    localparam logic [STB_W-1:0] c_STB_LAST  = STB_W'(STABLE_CNT - 1);
    localparam logic [RPT_W-1:0] c_HOLD_LAST = RPT_W'(HOLD_TICKS - 1);
    localparam logic [RPT_W-1:0] c_REP_LAST  = RPT_W'(REPEAT_TICKS - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [STB_W-1:0] r_stb_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_nxt;
    logic             w_rpt_fire;

    logic w_differ;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    // The level flips on the tick whose differing sample would complete the run
    assign w_differ  = (r_sync != r_level);
    assign w_flip    = tick && w_differ && (r_stb_cnt == c_STB_LAST);
    assign w_rise    = w_flip && !r_level;
    assign w_fall    = w_flip &&  r_level;
    assign press_set = w_rise;

    assign pb_level   = r_level;
    assign pb_press   = r_press;
    assign pb_release = r_release;
    assign pb_repeat  = r_repeat;

    // Two-flop synchronizer for the raw asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= pb_in;
            r_sync <= r_meta;
        end
    end

    // Stability counter, debounced level and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_cnt <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            if (tick) begin
                if (!w_differ || w_flip) begin
                    r_stb_cnt <= '0;
                end else begin
                    r_stb_cnt <= r_stb_cnt + 1'b1;
                end
            end
            if (w_flip) begin
                r_level <= ~r_level;
            end
        end
    end

    // Repeat FSM state, repeat counter and repeat pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RELEASED;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_repeat  <= w_rpt_fire;
        end
    end

    // Next-state logic; a release always wins over a repeat falling due
    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_rpt_fire    = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (w_rise) begin
                    w_state_nxt   = ST_HOLD_WAIT;
                    w_rpt_cnt_nxt = '0;
                end
            end
            ST_HOLD_WAIT: begin
                if (w_fall) begin
                    w_state_nxt   = ST_RELEASED;
                    w_rpt_cnt_nxt = '0;
                end else if (tick) begin
                    if (r_rpt_cnt == c_HOLD_LAST) begin
                        // Without auto-repeat the counter parks at its last value
                        if (REPEAT_EN != 0) begin
                            w_state_nxt   = ST_REPEATING;
                            w_rpt_fire    = 1'b1;
                            w_rpt_cnt_nxt = '0;
                        end
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
                end
            end
            ST_REPEATING: begin
                if (w_fall) begin
                    w_state_nxt   = ST_RELEASED;
                    w_rpt_cnt_nxt = '0;
                end else if (tick) begin
                    if (r_rpt_cnt == c_REP_LAST) begin
                        w_rpt_fire    = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_RELEASED;
                w_rpt_cnt_nxt = '0;
            end
        endcase
    end

endmodule : debounce_channel
`default_nettype wire

// File: rtl/btn_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_bank
//  Description : Bank of N_CH debounced push-button channels sharing one
//                sample-tick prescaler, with a registered any-press flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_bank
    import btn_debounce_pkg::*;
#(
    parameter int N_CH         = c_N_CH_DEFAULT,
    parameter int TICK_DIV     = c_TICK_DIV_DEFAULT,
    parameter int STABLE_CNT   = c_STABLE_CNT_DEFAULT,
    parameter int REPEAT_EN    = c_REPEAT_EN_DEFAULT,
    parameter int HOLD_TICKS   = c_HOLD_TICKS_DEFAULT,
    parameter int REPEAT_TICKS = c_REPEAT_TICKS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] pb_press,
    output logic [N_CH-1:0] pb_release,
    output logic [N_CH-1:0] pb_repeat,
    output logic            any_press
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_tick;
    logic [N_CH-1:0]  w_press_set;
    logic             r_any_press;

    assign w_tick    = (r_pre_cnt == c_PRE_LAST);
    assign any_press = r_any_press;

    // Shared prescaler: counts 0..TICK_DIV-1, tick on the terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // any_press is registered from the same terms that set pb_press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_set;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT   (STABLE_CNT),
            .REPEAT_EN    (REPEAT_EN),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (w_tick),
            .pb_in      (pb_in[i]),
            .pb_level   (pb_level[i]),
            .pb_press   (pb_press[i]),
            .pb_release (pb_release[i]),
            .pb_repeat  (pb_repeat[i]),
            .press_set  (w_press_set[i])
        );
    end

endmodule : btn_debounce_bank
`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce_bank
//  Description : Scoreboard bench for btn_debounce_bank. Two instances: dut_a
//                with auto-repeat, dut_b without. Expected output events are
//                queued with the sample-tick index they must appear on.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_btn_debounce_bank;

    localparam int NC = 4;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int HT = 5;
    localparam int RT = 2;

    typedef struct {
        logic [NC-1:0] press;
        logic [NC-1:0] rel;
        logic [NC-1:0] rpt;
        logic          any;
        logic [NC-1:0] lvl;
        int            tick;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NC-1:0] pb_a, pb_b;
    logic [NC-1:0] lvl_a, prs_a, rel_a, rpt_a;
    logic [NC-1:0] lvl_b, prs_b, rel_b, rpt_b;
    logic          any_a, any_b;

    ev_t q_a[$];
    ev_t q_b[$];
    int  cyc;
    bit  done = 1'b0;
    int  n_vec = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    btn_debounce_bank #(
        .N_CH(NC), .TICK_DIV(TD), .STABLE_CNT(SC), .REPEAT_EN(1),
        .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_a), .pb_level(lvl_a),
        .pb_press(prs_a), .pb_release(rel_a), .pb_repeat(rpt_a), .any_press(any_a)
    );

    btn_debounce_bank #(
        .N_CH(NC), .TICK_DIV(TD), .STABLE_CNT(SC), .REPEAT_EN(0),
        .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_b), .pb_level(lvl_b),
        .pb_press(prs_b), .pb_release(rel_b), .pb_repeat(rpt_b), .any_press(any_b)
    );

    // Bench-side cycle count since reset release; tick k lands on cyc == k*TD
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push_ev(input int side, input logic [NC-1:0] p, input logic [NC-1:0] r,
                           input logic [NC-1:0] t, input logic any, input logic [NC-1:0] lv,
                           input int tk);
        ev_t e;
        e.press = p; e.rel = r; e.rpt = t; e.any = any; e.lvl = lv; e.tick = tk;
        if (side == 0) q_a.push_back(e);
        else           q_b.push_back(e);
    endtask

    // Wait for n sample ticks, then return on the following falling edge
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do begin
                @(posedge clk);
                #1;
            end while (cyc % TD != 0);
        end
        @(negedge clk);
    endtask

    task automatic check_ev(input int side, input logic [NC-1:0] p, input logic [NC-1:0] r,
                            input logic [NC-1:0] t, input logic any, input logic [NC-1:0] lv);
        ev_t e;
        int  at;
        bit  empty;
        at = (cyc % TD == 0) ? cyc / TD : -1;
        n_vec++;
        empty = (side == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        if (empty) begin
            n_bad++;
            $display("FAIL dut%0d_unexpected_event tick=%0d press=%b rel=%b rpt=%b any=%b lvl=%b required no event",
                     side, at, p, r, t, any, lv);
        end else begin
            if (side == 0) e = q_a.pop_front();
            else           e = q_b.pop_front();
            if ({p, r, t, any, lv} !== {e.press, e.rel, e.rpt, e.any, e.lvl} || at != e.tick) begin
                n_bad++;
                $display("FAIL dut%0d_event actual tick=%0d press=%b rel=%b rpt=%b any=%b lvl=%b required tick=%0d press=%b rel=%b rpt=%b any=%b lvl=%b",
                         side, at, p, r, t, any, lv, e.tick, e.press, e.rel, e.rpt, e.any, e.lvl);
            end
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    endtask

    // Monitor: reset-state checks, event pops, final drain check, watchdog
    initial begin
        int wd;
        wd = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            wd++;
            if (wd > 20000) begin
                n_bad++;
                $display("FAIL watchdog actual=%0d edges required<=20000", wd);
                summary();
                $finish;
            end
            if (!rst_n) begin
                n_vec++;
                if ({lvl_a, prs_a, rel_a, rpt_a, any_a, lvl_b, prs_b, rel_b, rpt_b, any_b} != '0) begin
                    n_bad++;
                    $display("FAIL reset_outputs actual a=%b/%b/%b/%b/%b b=%b/%b/%b/%b/%b required all 0",
                             lvl_a, prs_a, rel_a, rpt_a, any_a, lvl_b, prs_b, rel_b, rpt_b, any_b);
                end
            end else begin
                if ((prs_a | rel_a | rpt_a) != '0 || any_a)
                    check_ev(0, prs_a, rel_a, rpt_a, any_a, lvl_a);
                if ((prs_b | rel_b | rpt_b) != '0 || any_b)
                    check_ev(1, prs_b, rel_b, rpt_b, any_b, lvl_b);
            end
            if (done) begin
                n_vec++;
                if (q_a.size() != 0) begin
                    n_bad++;
                    $display("FAIL dut0_missing_events actual=%0d pending required=0 (next tick=%0d)",
                             q_a.size(), q_a[0].tick);
                end
                n_vec++;
                if (q_b.size() != 0) begin
                    n_bad++;
                    $display("FAIL dut1_missing_events actual=%0d pending required=0 (next tick=%0d)",
                             q_b.size(), q_b[0].tick);
                end
                summary();
                $finish;
            end
        end
    end

    // Stimulus: each input change is made just after a tick edge, so a level
    // held for SC ticks flips on tick (t + SC) where t is the current tick.
    initial begin
        int t;
        int p;
        pb_a = '0;
        pb_b = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clean press and release on ch0
        wait_ticks(2);
        t = cyc / TD;
        pb_a[0] = 1'b1;
        push_ev(0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, t + SC);
        wait_ticks(3);
        t = cyc / TD;
        pb_a[0] = 1'b0;
        push_ev(0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0000, t + SC);
        wait_ticks(5);

        // Glitch of two ticks is rejected, three ticks is accepted
        pb_a[0] = 1'b1;
        wait_ticks(2);
        pb_a[0] = 1'b0;
        wait_ticks(5);
        t = cyc / TD;
        pb_a[0] = 1'b1;
        push_ev(0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, t + SC);
        wait_ticks(3);
        t = cyc / TD;
        pb_a[0] = 1'b0;
        push_ev(0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0000, t + SC);
        wait_ticks(5);

        // Long hold: repeats at press+5,+7,+9,+11; release at +13 beats a due repeat
        t = cyc / TD;
        pb_a[0] = 1'b1;
        p = t + SC;
        push_ev(0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, p);
        push_ev(0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, p + 5);
        push_ev(0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, p + 7);
        push_ev(0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, p + 9);
        push_ev(0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0001, p + 11);
        wait_ticks(13);
        pb_a[0] = 1'b0;
        push_ev(0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0000, p + 13);
        wait_ticks(10);

        // ch1 and ch3 together, held into repeating, then reset mid-hold
        t = cyc / TD;
        pb_a = 4'b1010;
        p = t + SC;
        push_ev(0, 4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b1010, p);
        push_ev(0, 4'b0000, 4'b0000, 4'b1010, 1'b0, 4'b1010, p + 5);
        push_ev(0, 4'b0000, 4'b0000, 4'b1010, 1'b0, 4'b1010, p + 7);
        wait_ticks(10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_ev(0, 4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b1010, SC);
        wait_ticks(3);
        t = cyc / TD;
        pb_a = 4'b0000;
        push_ev(0, 4'b0000, 4'b1010, 4'b0000, 1'b0, 4'b0000, t + SC);
        wait_ticks(5);

        // No auto-repeat instance: 20-tick hold on ch2
        t = cyc / TD;
        pb_b[2] = 1'b1;
        push_ev(1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, t + SC);
        wait_ticks(20);
        t = cyc / TD;
        pb_b[2] = 1'b0;
        push_ev(1, 4'b0000, 4'b0100, 4'b0000, 1'b0, 4'b0000, t + SC);
        wait_ticks(6);

        done = 1'b1;
    end

endmodule : tb_btn_debounce_bank
`default_nettype wire

// File: doc/btn_debounce_bank.md
BTN_DEBOUNCE_BANK -- requirements
Module: btn_debounce_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels (>=1).
REQ-002 SHALL have parameter TICK_DIV, default 250000: clk cycles per sample tick (>=2).
REQ-003 SHALL have parameter STABLE_CNT, default 4: consecutive differing samples needed to flip a channel level (>=1).
REQ-004 SHALL have parameter REPEAT_EN, default 1: enables auto-repeat pulses (0 or 1).
REQ-005 SHALL have parameter HOLD_TICKS, default 100: ticks from press to first repeat (>=1).
REQ-006 SHALL have parameter REPEAT_TICKS, default 25: ticks between later repeats (>=1).
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 SHALL have port pb_in, input, N_CH: raw asynchronous button inputs, active-high.
REQ-010 SHALL have port pb_level, output, N_CH: debounced level per channel.
REQ-011 SHALL have port pb_press, output, N_CH: one-clk pulse on a debounced rising edge.
REQ-012 SHALL have port pb_release, output, N_CH: one-clk pulse on a debounced falling edge.
REQ-013 SHALL have port pb_repeat, output, N_CH: one-clk auto-repeat pulse while held.
REQ-014 SHALL have port any_press, output, 1: OR of pb_press, registered in the same cycle.

Function
REQ-015 SHALL run one shared prescaler counting 0..TICK_DIV-1 and wrapping to 0; tick is high for exactly the one cycle when the count equals TICK_DIV-1.
REQ-016 SHALL pass each pb_in bit through a two-flop synchronizer; only the second flop output (sync) feeds any other logic.
REQ-017 SHALL, on each tick, per channel: if sync != pb_level, increment the stability counter; otherwise clear it to 0.
REQ-018 SHALL flip pb_level and clear the counter on the tick edge where the counter would reach STABLE_CNT; counter width SHALL be $clog2(STABLE_CNT+1) and it SHALL never exceed STABLE_CNT-1.
REQ-019 SHALL ignore any glitch that lasts fewer than STABLE_CNT consecutive differing samples; one equal sample restarts the count.
REQ-020 SHALL assert pb_press or pb_release on the same clk edge on which pb_level changes, for exactly one cycle.
REQ-021 SHALL run a per-channel FSM with states RELEASED, HOLD_WAIT, REPEATING.
REQ-022 SHALL implement these FSM transitions: RELEASED->HOLD_WAIT on press, loading repeat counter 0; HOLD_WAIT->REPEATING with a pb_repeat pulse when the HOLD_TICKS-th tick after press occurs; in REPEATING, pulse pb_repeat every REPEAT_TICKS ticks; any state->RELEASED on release.
REQ-023 SHALL keep the FSM in RELEASED/HOLD_WAIT only, and never assert pb_repeat, when REPEAT_EN=0.
REQ-024 SHALL never assert pb_repeat in the same cycle as pb_press or pb_release; release takes priority over a due repeat.
REQ-025 SHALL size the repeat counter at $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1) bits; it SHALL saturate-free wrap only by reload, never by overflow.
REQ-026 SHALL keep channels fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-027 SHALL give worst-case press latency from a stable pb_in edge to pb_level of 2 + STABLE_CNT*TICK_DIV clk cycles.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously clear the prescaler, synchronizers, stability and repeat counters, set FSMs to RELEASED, and drive all outputs 0.
REQ-029 SHALL produce the first tick TICK_DIV cycles after rst_n deasserts; a button held through reset is reported as a fresh press.

Structure
REQ-030 SHALL put the FSM state enum and the default parameter constants in package btn_debounce_pkg.
REQ-031 SHALL instantiate sub-module debounce_channel N_CH times, holding synchronizer, stability counter, FSM and repeat counter; the prescaler and any_press stay in the top level.

Verification (TICK_DIV=4, STABLE_CNT=3, HOLD_TICKS=5, REPEAT_TICKS=2)
REQ-032 SHALL test a clean press on ch0: pb_level[0] rises within 14 clks with a single 1-clk pb_press[0] and any_press.
REQ-033 SHALL test glitch rejection: high for 2 ticks then low leaves pb_level 0 with no pulses; high for 3 ticks produces a press.
REQ-034 SHALL test a hold of 12 ticks: pb_repeat at ticks 5, 7, 9 and 11 after press, then a release pulse and no further repeats.
REQ-035 SHALL test ch1 and ch3 pressed in the same cycle: both pb_press bits asserted in one cycle and any_press high for one cycle.
REQ-036 SHALL test rst_n pulled low mid-REPEATING: all outputs 0 immediately; after release of reset, the still-held button produces a new pb_press.
REQ-037 SHALL test REPEAT_EN=0 with a 20-tick hold: exactly one press, one release, and pb_repeat never asserted.
